// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage with IF/ID pipeline register.
// Owns the fetch PC, runs the imem read handshake, and absorbs stalls and redirects.
module fetch_stage #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_address,
  output logic             imem_read,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             valid_out,
  output logic [3:0]       opcode_out,
  output logic             ir_4,
  output logic             ir_5,
  output logic             ir_11
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           r_state;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_redir;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_pc;
  logic             r_valid;

  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_addrNext;

  assign w_target   = redirect_target & ALIGN_MASK;
  assign w_addrNext = r_addr + WIDTH'(2);

  // HOLD is the only state without a request in flight.
  assign imem_read    = (r_state != HOLD);
  assign imem_address = r_addr;

  assign ir_out     = r_ir;
  assign pc_out     = r_pc;
  assign valid_out  = r_valid;
  assign opcode_out = r_ir[15:12];
  assign ir_4       = r_ir[4];
  assign ir_5       = r_ir[5];
  assign ir_11      = r_ir[11];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_addr  <= RESET_PC;
      r_redir <= '0;
      r_buf   <= '0;
      r_ir    <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_valid) begin
            r_valid <= 1'b0;
            // The in-flight request must still complete before the new target can be issued.
            if (imem_resp) begin
              r_addr <= w_target;
            end else begin
              r_redir <= w_target;
              r_state <= DISCARD;
            end
          end else if (imem_resp) begin
            r_addr <= w_addrNext;
            if (stall) begin
              r_buf   <= imem_rdata;
              r_state <= HOLD;
            end else begin
              r_ir    <= imem_rdata;
              r_pc    <= w_addrNext;
              r_valid <= 1'b1;
            end
          end else if (!stall) begin
            r_valid <= 1'b0;
          end
        end

        DISCARD: begin
          r_valid <= 1'b0;
          if (imem_resp) begin
            r_addr  <= redirect_valid ? w_target : r_redir;
            r_state <= FETCH;
          end else if (redirect_valid) begin
            r_redir <= w_target;
          end
        end

        HOLD: begin
          // r_addr was already advanced when the word was buffered, so it is the PC+2.
          if (redirect_valid) begin
            r_valid <= 1'b0;
            r_addr  <= w_target;
            r_state <= FETCH;
          end else if (!stall) begin
            r_ir    <= r_buf;
            r_pc    <= r_addr;
            r_valid <= 1'b1;
            r_state <= FETCH;
          end
        end

        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a program-flow model predicts the
// instruction stream decode should see, and a negedge monitor checks it.
module tb_fetch_stage;

  localparam logic [15:0] TB_RESET_PC = 16'h0000;
  localparam int NPH = 7;
  localparam int RESET_PHASE = 5;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic [3:0]  opcode_out;
  logic        ir_4;
  logic        ir_5;
  logic        ir_11;

  int total = 0;
  int bad = 0;

  exp_t        expQ[$];
  exp_t        monItem;
  logic        monEn;
  logic [15:0] reqAddr;
  logic [15:0] pendTarget;
  logic        stale;
  logic        skid;
  logic        expValid;

  int phCycles [NPH] = '{40, 60, 80, 80, 100, 80, 80};
  int phResp   [NPH] = '{100, 50, 70, 60, 80, 70, 100};
  int phStall  [NPH] = '{0, 0, 30, 25, 40, 30, 20};
  int phRedir  [NPH] = '{0, 0, 0, 10, 15, 15, 10};

  fetch_stage #(
    .WIDTH(16),
    .RESET_PC(TB_RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_address(imem_address),
    .imem_read(imem_read),
    .imem_resp(imem_resp),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .ir_out(ir_out),
    .pc_out(pc_out),
    .valid_out(valid_out),
    .opcode_out(opcode_out),
    .ir_4(ir_4),
    .ir_5(ir_5),
    .ir_11(ir_11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a fixed function of the word address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [15:0] t, input logic p);
    stall           = s;
    redirect_valid  = r;
    redirect_target = t;
    imem_resp       = p;
    imem_rdata      = p ? memWord(imem_address) : 16'($urandom);
  endtask

  // Program-flow model: a redirect flushes everything younger and restarts at the
  // target once the in-flight read is gone; a word that decode cannot take is parked.
  task automatic updateModel(input logic s, input logic r, input logic [15:0] t, input logic p);
    exp_t item;
    if (r) begin
      expQ.delete();
      expValid = 1'b0;
      if (skid) begin
        skid = 1'b0;
        reqAddr = t;
        stale = 1'b0;
      end else if (p) begin
        reqAddr = t;
        stale = 1'b0;
      end else begin
        stale = 1'b1;
        pendTarget = t;
      end
    end else if (p) begin
      if (stale) begin
        stale = 1'b0;
        reqAddr = pendTarget;
        if (!s) expValid = 1'b0;
      end else begin
        item.ir = memWord(reqAddr);
        item.pc = reqAddr + 16'd2;
        expQ.push_back(item);
        reqAddr = reqAddr + 16'd2;
        if (s) skid = 1'b1;
        else expValid = 1'b1;
      end
    end else if (skid && !s) begin
      skid = 1'b0;
      expValid = 1'b1;
    end else if (!s) begin
      expValid = 1'b0;
    end
  endtask

  task automatic doReset();
    monEn = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ir_out", 32'(ir_out), 32'h0);
    checkOutput("rst_pc_out", 32'(pc_out), 32'h0);
    checkOutput("rst_valid_out", 32'(valid_out), 32'h0);
    checkOutput("rst_opcode", 32'(opcode_out), 32'h0);
    checkOutput("rst_imem_read", 32'(imem_read), 32'h1);
    checkOutput("rst_imem_address", 32'(imem_address), 32'(TB_RESET_PC));
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    reqAddr = TB_RESET_PC;
    pendTarget = 16'h0000;
    stale = 1'b0;
    skid = 1'b0;
    expValid = 1'b0;
    @(posedge clk);
    updateModel(1'b0, 1'b0, 16'h0000, 1'b0);
    #1;
    monEn = 1'b1;
  endtask

  task automatic runCycle(input int respPct, input int stallPct, input int redirPct);
    logic        s, r, p;
    logic [15:0] t;
    s = ($urandom % 100) < stallPct;
    r = ($urandom % 100) < redirPct;
    case ($urandom_range(0, 3))
      0: t = 16'($urandom);
      1: t = 16'hFFFC;
      2: t = 16'hFFFF;
      default: t = 16'h0040;
    endcase
    p = !skid && (($urandom % 100) < respPct);
    applyStimulus(s, r, t, p);
    @(posedge clk);
    updateModel(s, r, t & 16'hFFFE, p);
    #1;
  endtask

  // Monitor: compares handshake and IF/ID against the model; pops on every hand-off to decode.
  initial begin
    forever begin
      @(negedge clk);
      if (monEn) begin
        checkOutput("valid_out", 32'(valid_out), 32'(expValid));
        checkOutput("imem_read", 32'(imem_read), 32'(!skid));
        if (!skid) checkOutput("imem_address", 32'(imem_address), 32'(reqAddr));
        if (valid_out && !stall && !redirect_valid) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL extra_instr actual=ir_%h expected=no_instruction at %0t", ir_out, $time);
          end else begin
            monItem = expQ.pop_front();
            checkOutput("ir_out", 32'(ir_out), 32'(monItem.ir));
            checkOutput("pc_out", 32'(pc_out), 32'(monItem.pc));
            checkOutput("opcode_out", 32'(opcode_out), 32'(monItem.ir[15:12]));
            checkOutput("ir_bits", 32'({ir_11, ir_5, ir_4}), 32'({monItem.ir[11], monItem.ir[5], monItem.ir[4]}));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    monEn = 1'b0;
    reqAddr = TB_RESET_PC;
    pendTarget = 16'h0000;
    stale = 1'b0;
    skid = 1'b0;
    expValid = 1'b0;
    doReset();
    for (int ph = 0; ph < NPH; ph++) begin
      if (ph == RESET_PHASE) doReset();
      for (int c = 0; c < phCycles[ph]; c++) runCycle(phResp[ph], phStall[ph], phRedir[ph]);
    end
    for (int c = 0; c < 4; c++) runCycle(0, 0, 0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    monEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined LC-3b datapath. It owns the fetch PC and drives the instruction-memory read handshake. It presents the fetched instruction, its PC+2 and a valid bit to decode. Its opcode and the IR bits 4, 5 and 11 feed the control-word decoder directly. It also absorbs downstream stalls and branch/jump/trap redirects.

Parameters:
WIDTH, 16, instruction and address width.
RESET_PC, 16'h0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
imem_address  out  WIDTH  address of the outstanding instruction read.
imem_read  out  1  read request; held high until imem_resp.
imem_resp  in  1  one-cycle response strobe; imem_rdata valid in that cycle.
imem_rdata  in  WIDTH  instruction word.
stall  in  1  decode cannot accept a new instruction this cycle.
redirect_valid  in  1  control transfer resolved downstream; flush and refetch.
redirect_target  in  WIDTH  new fetch address (bit 0 ignored, forced 0).
ir_out  out  WIDTH  IF/ID instruction register.
pc_out  out  WIDTH  IF/ID PC+2 of ir_out.
valid_out  out  1  IF/ID holds a real instruction; 0 means bubble.
opcode_out  out  4  ir_out[15:12].
ir_4, ir_5, ir_11  out  1 each  ir_out bits 4, 5 and 11.

Behaviour:
- Registers:
  - addr_q: current request address, drives imem_address.
  - redir_q: pending redirect target.
  - buf_q: one-entry skid buffer.
  - IF/ID: ir_out, pc_out, valid_out.
  - state.
- Reset (async, rst_n=0):
  - state=FETCH, addr_q=RESET_PC, redir_q=0, buf_q=0.
  - ir_out=0, pc_out=0, valid_out=0.
  - imem_read=1 in the first cycle after reset deassertion.
  - Reset mid-request abandons it; no response is consumed afterwards unless a new request is issued.
- imem_read = 1 in FETCH and DISCARD, 0 in HOLD. imem_address = addr_q, stable while imem_read=1 and imem_resp=0.
- PC+2 arithmetic is modulo 2^WIDTH: 16'hFFFE+2 = 16'h0000.
- State FETCH:
  - redirect_valid=1, any imem_resp: clear valid_out regardless of stall.
    - With imem_resp: drop the data, addr_q<=target, stay FETCH.
    - Without imem_resp: redir_q<=target, go to DISCARD.
  - imem_resp=1, stall=0: ir_out<=rdata, pc_out<=addr_q+2, valid_out<=1, addr_q<=addr_q+2, stay FETCH.
  - imem_resp=1, stall=1: buf_q<=rdata, addr_q<=addr_q+2, go to HOLD. IF/ID is unchanged.
  - imem_resp=0, stall=0: valid_out<=0 (bubble). imem_resp=0, stall=1: IF/ID unchanged.
- State DISCARD (a request is outstanding to a now-stale address):
  - Stall is ignored for the flushed path; valid_out stays 0.
  - redirect_valid=1: redir_q<=new target (latest redirect wins).
  - imem_resp=1: drop the data, addr_q<=redir_q, or the new target if redirect_valid is set the same cycle; go to FETCH.
- State HOLD (buf_q valid, no request outstanding):
  - redirect_valid=1: discard buf_q, clear valid_out, addr_q<=target, go to FETCH.
  - stall=0: ir_out<=buf_q, pc_out<=addr_q, valid_out<=1, go to FETCH.
  - stall=1: stay in HOLD, all registers unchanged.
- Priorities: rst_n > redirect_valid > imem_resp/stall. A redirect never truncates a memory handshake.
- Latency:
  - Back-to-back with single-cycle memory, no stalls: one instruction per cycle, valid_out one cycle after imem_resp.
  - After a redirect: first post-redirect valid_out at least 2 cycles later.
- opcode_out and the ir_* bits are pure slices of ir_out, with no extra delay.

Test Plan:
- Reset with RESET_PC=0, memory responding every cycle with words 16'h1234 then 16'h5678 -> imem_address 0 then 2; ir_out=16'h1234, pc_out=2, then ir_out=16'h5678, pc_out=4; valid_out=1 both cycles.
- Memory response delayed 3 cycles, stall=0 -> imem_read and imem_address=0 held steady for 3 cycles, valid_out=0 each wait cycle, then ir_out loads.
- stall=1 when the response 16'h1DA5 arrives at address 6 -> state HOLD, imem_read=0, IF/ID unchanged. Deassert stall -> ir_out=16'h1DA5, pc_out=8, fetch resumes at 8.
- redirect_valid with target 16'h0040 while the request to address 10 is outstanding -> address 10 held until resp, data dropped, valid_out=0, next request address 16'h0040.
- Two redirects in DISCARD (16'h0040 then 16'h0080) -> fetch resumes at 16'h0080 only.
- addr_q=16'hFFFE, response received -> pc_out=16'h0000 and the next address wraps to 16'h0000. rst_n pulsed low mid-request -> outputs zero immediately, restart at RESET_PC.
